aes_inv_cipher_seq: RTL and testbench



---
 rtl/aes_inv_cipher_seq_pkg.sv | 144 ++++++++++++++
 rtl/aes_inv_cipher_seq_if.sv | 22 ++
 rtl/aes_inv_round_comb.sv | 26 ++
 rtl/aes_inv_cipher_seq.sv | 101 ++++++++++
 tb/tb_aes_inv_cipher_seq.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_inv_cipher_seq_pkg.sv
// AES inverse cipher shared package: modes, round counts, FSM states
// and the GF(2^8) / inverse-round helper functions.
package aes_inv_pkg;

   localparam logic [1:0] MODE_128 = 2'd0;
   localparam logic [1:0] MODE_192 = 2'd1;
   localparam logic [1:0] MODE_256 = 2'd2;
   localparam logic [1:0] MODE_RSV = 2'd3;

   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERR,
      S_INIT,
      S_ROUND,
      S_FINAL,
      S_DONE
   } fsm_e;

   function automatic logic [3:0] nr_of(input logic [1:0] m);
      logic [3:0] n;
      case (m)
         MODE_192: n = NR_192;
         MODE_256: n = NR_256;
         default:  n = NR_128;
      endcase
      return n;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] s;
      case (b)
         8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5;
         8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
         8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e;
         8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
         8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82;
         8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
         8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44;
         8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
         8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32;
         8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
         8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b;
         8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
         8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66;
         8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
         8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49;
         8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
         8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64;
         8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
         8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc;
         8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
         8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50;
         8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
         8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57;
         8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
         8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00;
         8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
         8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05;
         8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
         8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f;
         8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
         8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03;
         8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
         8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41;
         8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
         8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce;
         8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
         8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22;
         8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
         8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8;
         8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
         8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71;
         8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
         8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e;
         8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
         8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b;
         8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
         8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe;
         8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
         8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33;
         8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
         8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59;
         8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
         8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9;
         8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
         8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f;
         8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
         8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d;
         8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
         8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c;
         8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
         8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e;
         8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
         8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63;
         8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul09(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ a;
   endfunction

   function automatic logic [7:0] gmul0b(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
   endfunction

   function automatic logic [7:0] gmul0d(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
   endfunction

   function automatic logic [7:0] gmul0e(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
   endfunction

   // Byte r+4c sits at row r, column c; row r rotates right by r.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3),
              gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3),
              gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3),
              gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3)};
   endfunction

endpackage

// File: rtl/aes_inv_cipher_seq_if.sv
// Ciphertext-in / plaintext-out valid/ready bundle for the inverse cipher.
interface aes_inv_cipher_seq_if #(
   parameter int MODE_W = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [MODE_W-1:0] mode;
   logic [127:0]      ciphertext;
   logic              out_valid;
   logic              out_ready;
   logic [127:0]      plaintext;

   modport master (
      output in_valid, mode, ciphertext, out_ready,
      input  in_ready, out_valid, plaintext
   );

   modport slave (
      input  in_valid, mode, ciphertext, out_ready,
      output in_ready, out_valid, plaintext
   );
endinterface

// File: rtl/aes_inv_round_comb.sv
// One inverse AES round, combinational; FINAL skips InvMixColumns.
module aes_inv_round_comb (
   input  logic [127:0] i_state,
   input  logic [127:0] i_rk,
   input  logic         i_skip_mix,
   output logic [127:0] o_state
);
   import aes_inv_pkg::*;

   logic [127:0] w_sr;
   logic [127:0] w_sb;
   logic [127:0] w_ark;
   logic [127:0] w_mix;

   always_comb begin
      w_sr = inv_shift_rows(i_state);
      w_sb = '0;
      for (int i = 0; i < 16; i++)
         w_sb[127-8*i -: 8] = inv_sbox(w_sr[127-8*i -: 8]);
      w_ark = w_sb ^ i_rk;
      w_mix = '0;
      for (int c = 0; c < 4; c++)
         w_mix[127-32*c -: 32] = inv_mix_column(w_ark[127-32*c -: 32]);
      o_state = i_skip_mix ? w_ark : w_mix;
   end
endmodule

// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES-128/192/256 inverse cipher, one round per clock,
// round keys fetched from an external store by index.
module aes_inv_cipher_seq #(
   parameter int MODE_W = 2,
   parameter int RKI_W  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   aes_inv_cipher_seq_if.slave bus,
   output logic [RKI_W-1:0]   rk_idx,
   input  logic [127:0]       rk,
   output logic               busy,
   output logic               err
);
   import aes_inv_pkg::*;

   fsm_e              r_fsm;
   fsm_e              w_fsm_nxt;
   logic [127:0]      r_state;
   logic [127:0]      r_pt;
   logic [RKI_W-1:0]  r_cnt;
   logic [MODE_W-1:0] w_mode;
   logic [127:0]      w_rnd;
   logic              w_acc;
   logic              w_final;

   assign w_mode  = bus.mode;
   assign w_acc   = bus.in_valid && (r_fsm == S_IDLE);
   assign w_final = (r_fsm == S_FINAL);

   aes_inv_round_comb u_round (
      .i_state    (r_state),
      .i_rk       (rk),
      .i_skip_mix (w_final),
      .o_state    (w_rnd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_fsm <= S_IDLE;
      else        r_fsm <= w_fsm_nxt;
   end

   always_comb begin
      w_fsm_nxt = r_fsm;
      rk_idx    = '0;
      unique case (r_fsm)
         S_IDLE: begin
            if (w_acc)
               w_fsm_nxt = (w_mode == MODE_RSV) ? S_ERR : S_INIT;
         end
         S_ERR: w_fsm_nxt = S_IDLE;
         S_INIT: begin
            rk_idx    = r_cnt;
            w_fsm_nxt = S_ROUND;
         end
         S_ROUND: begin
            rk_idx = r_cnt;
            if (r_cnt == RKI_W'(1)) w_fsm_nxt = S_FINAL;
         end
         S_FINAL: w_fsm_nxt = S_DONE;
         S_DONE: begin
            if (bus.out_ready) w_fsm_nxt = S_IDLE;
         end
         default: w_fsm_nxt = S_IDLE;
      endcase
   end

   // The counter captures Nr at accept, so later mode changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= '0;
         r_pt    <= '0;
         r_cnt   <= '0;
      end else begin
         unique case (r_fsm)
            S_IDLE: begin
               if (w_acc) begin
                  r_state <= bus.ciphertext;
                  r_cnt   <= RKI_W'(nr_of(w_mode));
               end
            end
            S_INIT: begin
               r_state <= r_state ^ rk;
               r_cnt   <= r_cnt - RKI_W'(1);
            end
            S_ROUND: begin
               r_state <= w_rnd;
               r_cnt   <= r_cnt - RKI_W'(1);
            end
            S_FINAL: r_pt <= w_rnd;
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_fsm == S_IDLE);
   assign bus.out_valid = (r_fsm == S_DONE);
   assign bus.plaintext = r_pt;
   assign busy          = (r_fsm != S_IDLE);
   assign err           = (r_fsm == S_ERR);
endmodule

// File: tb/tb_aes_inv_cipher_seq.sv
// Directed FIPS-197 vectors for the iterative AES inverse cipher,
// with a forward key-schedule model acting as the round-key store.
module tb_aes_inv_cipher_seq;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K1  =
      {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K2  =
      {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K3  =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   logic         clk;
   logic         rst_n;
   logic [3:0]   rk_idx;
   logic [127:0] rk;
   logic         busy;
   logic         err;
   logic [127:0] rks [16];

   int n_chk  = 0;
   int n_fail = 0;

   aes_inv_cipher_seq_if #(.MODE_W(2)) bus ();

   aes_inv_cipher_seq #(.MODE_W(2), .RKI_W(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .rk_idx (rk_idx),
      .rk     (rk),
      .busy   (busy),
      .err    (err)
   );

   assign rk = rks[rk_idx];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] sb(input logic [7:0] b);
      return SBOX[2047-8*int'(b) -: 8];
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
   endfunction

   // FIPS-197 forward key expansion filling the round-key store.
   task automatic load_keys(input logic [255:0] key, input int nk);
      logic [31:0] w [64];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < 64; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int k = 0; k < 16; k++)
         rks[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
   endtask

   task automatic start_block(input string tag, input logic [127:0] ct,
                              input logic [1:0] m);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         tick;
         n++;
      end
      chk({tag, " in_ready"}, 256'(bus.in_ready), 256'(1));
      bus.ciphertext = ct;
      bus.mode       = m;
      bus.in_valid   = 1'b1;
      tick;
      bus.in_valid   = 1'b0;
      bus.mode       = 2'd3;
      bus.ciphertext = '0;
   endtask

   task automatic wait_out(input string tag, input int nr,
                           input logic [127:0] exp_pt);
      logic [63:0] so;
      logic [63:0] se;
      int          n;
      so = '0;
      se = '0;
      n  = 0;
      while (!bus.out_valid && n < 40) begin
         so = {so[59:0], rk_idx};
         se = {se[59:0], (n <= nr) ? 4'(nr - n) : 4'hf};
         tick;
         n++;
      end
      chk({tag, " latency"}, 256'(n), 256'(nr + 1));
      chk({tag, " rk_idx seq"}, 256'(so), 256'(se));
      chk({tag, " plaintext"}, 256'(bus.plaintext), 256'(exp_pt));
   endtask

   logic [127:0] ct_v  [3];
   logic [1:0]   md_v  [3];
   logic [255:0] key_v [3];
   int           nk_v  [3];

   initial begin
      int   src;
      int   got;
      int   cnt;
      logic acc;
      logic hs;
      logic [127:0] pt_hold;

      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.mode       = 2'd0;
      bus.ciphertext = '0;
      bus.out_ready  = 1'b1;
      for (int k = 0; k < 16; k++) rks[k] = '0;
      ct_v[0] = CT1; md_v[0] = 2'd0; key_v[0] = K1; nk_v[0] = 4;
      ct_v[1] = CT2; md_v[1] = 2'd1; key_v[1] = K2; nk_v[1] = 6;
      ct_v[2] = CT3; md_v[2] = 2'd2; key_v[2] = K3; nk_v[2] = 8;

      tick;
      tick;
      chk("reset outputs",
          256'({bus.in_ready, bus.out_valid, busy, err, rk_idx}),
          256'({1'b1, 1'b0, 1'b0, 1'b0, 4'h0}));
      chk("reset plaintext", 256'(bus.plaintext), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick;

      // AES-128 with out_ready already high
      load_keys(K1, 4);
      start_block("c1", CT1, 2'd0);
      chk("c1 busy", 256'(busy), 256'(1));
      wait_out("c1", 10, PT);
      chk("c1 out_valid", 256'(bus.out_valid), 256'(1));
      tick;
      chk("c1 release",
          256'({bus.out_valid, bus.in_ready}), 256'({1'b0, 1'b1}));

      load_keys(K2, 6);
      start_block("c2", CT2, 2'd1);
      wait_out("c2", 12, PT);
      tick;

      load_keys(K3, 8);
      start_block("c3", CT3, 2'd2);
      wait_out("c3", 14, PT);
      tick;

      // Back-pressure on the output
      bus.out_ready = 1'b0;
      load_keys(K1, 4);
      start_block("bp", CT1, 2'd0);
      wait_out("bp", 10, PT);
      pt_hold = bus.plaintext;
      for (int i = 0; i < 20; i++) begin
         tick;
         chk("bp hold",
             256'({bus.out_valid, bus.in_ready, bus.plaintext}),
             256'({1'b1, 1'b0, pt_hold}));
      end
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      chk("bp release",
          256'({bus.out_valid, bus.in_ready}), 256'({1'b0, 1'b1}));
      bus.out_ready = 1'b1;

      // Reserved mode
      chk("err idle", 256'(err), 256'(0));
      bus.mode     = 2'd3;
      bus.in_valid = 1'b1;
      tick;
      bus.in_valid = 1'b0;
      bus.mode     = 2'd0;
      chk("err pulse",
          256'({err, bus.in_ready}), 256'({1'b1, 1'b0}));
      tick;
      chk("err done",
          256'({err, bus.in_ready}), 256'({1'b0, 1'b1}));
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (err || bus.out_valid) cnt++;
         tick;
      end
      chk("err quiet", 256'(cnt), 256'(0));

      // Asynchronous reset during an AES-256 round
      load_keys(K3, 8);
      start_block("rst", CT3, 2'd2);
      for (int i = 0; i < 5; i++) tick;
      chk("rst busy", 256'(busy), 256'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst async",
          256'({bus.in_ready, bus.out_valid, busy, err, rk_idx}),
          256'({1'b1, 1'b0, 1'b0, 1'b0, 4'h0}));
      chk("rst plaintext", 256'(bus.plaintext), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (bus.out_valid) cnt++;
      end
      chk("rst no output", 256'(cnt), 256'(0));
      load_keys(K1, 4);
      start_block("post", CT1, 2'd0);
      wait_out("post", 10, PT);
      tick;

      // Back-to-back queue with in_valid held high
      src            = 0;
      got            = 0;
      bus.ciphertext = ct_v[0];
      bus.mode       = md_v[0];
      bus.in_valid   = 1'b1;
      for (int cyc = 0; cyc < 200 && got < 3; cyc++) begin
         acc = bus.in_valid && bus.in_ready;
         hs  = bus.out_valid && bus.out_ready;
         if (hs) begin
            chk($sformatf("b2b pt %0d", got),
                256'(bus.plaintext), 256'(PT));
            got++;
         end
         tick;
         if (acc) begin
            load_keys(key_v[src], nk_v[src]);
            src++;
            if (src < 3) begin
               bus.ciphertext = ct_v[src];
               bus.mode       = md_v[src];
            end else begin
               bus.in_valid = 1'b0;
            end
         end
      end
      chk("b2b outputs", 256'(got), 256'(3));
      chk("b2b accepts", 256'(src), 256'(3));
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.out_valid) cnt++;
         tick;
      end
      chk("b2b no extra", 256'(cnt), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
